// File: rtl/arith_pkg.sv
// Shared arithmetic-unit types: controller state encodings for the divider
// and multiplier, plus the iteration-counter width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_SHIFT = 2'd1,
        DIV_DONE  = 2'd2
    } div_state_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_ADD  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Counter must hold the value N itself, hence N+1 codes.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_datapath.sv
// Restoring-division datapath: A/Q/M registers and one shift-subtract step
// per do_shift, loaded by do_init. Exposes the step result for capture.
module restoring_divider_datapath
    import arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         do_init_i,
    input  logic         do_shift_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] q_next_o,
    output logic [N-1:0] r_next_o
);

    logic [N:0]   a_q, a_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] m_q, m_d;
    logic [N+1:0] ext_s;
    logic [N+1:0] diff_s;
    logic         neg_s;
    logic [N:0]   a_step_s;
    logic [N-1:0] q_step_s;

    // One extra guard bit keeps the trial subtraction sign exact even though
    // the shifted partial remainder can reach 2^N.
    always_comb begin
        ext_s  = {a_q, q_q[N-1]};
        diff_s = ext_s - {2'b00, m_q};
        neg_s  = diff_s[N+1];
        if (neg_s) begin
            a_step_s = ext_s[N:0];
        end else begin
            a_step_s = diff_s[N:0];
        end
        q_step_s = {q_q[N-2:0], ~neg_s};
    end

    // Register next-state selection: load, step, or hold.
    always_comb begin
        if (do_init_i) begin
            a_d = {(N+1){1'b0}};
            q_d = dividend_i;
            m_d = divisor_i;
        end else if (do_shift_i) begin
            a_d = a_step_s;
            q_d = q_step_s;
            m_d = m_q;
        end else begin
            a_d = a_q;
            q_d = q_q;
            m_d = m_q;
        end
    end

    // A/Q/M state registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            a_q <= {(N+1){1'b0}};
            q_q <= {N{1'b0}};
            m_q <= {N{1'b0}};
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            m_q <= m_d;
        end
    end

    assign q_next_o = q_step_s;
    assign r_next_o = a_step_s[N-1:0];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: controller FSM and iteration counter.
// Optional macro RESTORING_DIVIDER_DIV0_FLAG_EN adds the div_by_zero output.
module restoring_divider
    import arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
`ifdef RESTORING_DIVIDER_DIV0_FLAG_EN
    ,
    output logic         div_by_zero
`endif
);

    localparam int CW = count_width(N);

    div_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic         busy_q, done_q;
    logic [N-1:0] quot_q, rem_q;
    logic         do_init_s, do_shift_s, last_s;
    logic [N-1:0] q_next_s, r_next_s;

    restoring_divider_datapath #(.N(N)) u_datapath (
        .clock_i    (clock),
        .reset_i    (reset),
        .do_init_i  (do_init_s),
        .do_shift_i (do_shift_s),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .q_next_o   (q_next_s),
        .r_next_o   (r_next_s)
    );

    // Controller next-state and datapath strobes.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        do_init_s  = 1'b0;
        do_shift_s = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    do_init_s = 1'b1;
                    count_d   = CW'(N);
                    state_d   = DIV_SHIFT;
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_SHIFT: begin
                do_shift_s = 1'b1;
                count_d    = count_q - CW'(1'b1);
                if (count_q == CW'(1'b1)) begin
                    state_d = DIV_DONE;
                end else begin
                    state_d = DIV_SHIFT;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign last_s = (state_q == DIV_SHIFT) && (count_q == CW'(1'b1));

    // Controller state, handshake outputs and result capture on entry to DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            count_q <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= {N{1'b0}};
            rem_q   <= {N{1'b0}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= (state_d != DIV_IDLE);
            done_q  <= last_s;
            if (last_s) begin
                quot_q <= q_next_s;
                rem_q  <= r_next_s;
            end else begin
                quot_q <= quot_q;
                rem_q  <= rem_q;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

`ifdef RESTORING_DIVIDER_DIV0_FLAG_EN
    logic div0_q, dbz_q;

    // Zero-divisor flag captured at acceptance, shown only in the DONE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            div0_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            if (do_init_s) begin
                div0_q <= (divisor == {N{1'b0}});
            end else begin
                div0_q <= div0_q;
            end
            dbz_q <= last_s & div0_q;
        end
    end

    assign div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus random
// operands checked against plain integer division.
module tb_restoring_divider;

    localparam int N = 4;

    logic         clock;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
`ifdef RESTORING_DIVIDER_DIV0_FLAG_EN
    logic         div_by_zero;
`endif

    int n_cmp = 0;
    int n_err = 0;

    restoring_divider #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef RESTORING_DIVIDER_DIV0_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at the negedge just after the accepting edge; waits for done and checks.
    task automatic finish_div(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
        int edges;
        logic [N-1:0] exp_q, exp_r;
        if (b == '0) begin
            exp_q = '1;
            exp_r = a;
        end else begin
            exp_q = N'(int'(a) / int'(b));
            exp_r = N'(int'(a) % int'(b));
        end
        edges = 1;
        if (!hold) start = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        check_value("busy_after_accept", 32'(busy), 32'd1);
        while (done !== 1'b1 && edges < 40) begin
            @(negedge clock);
            edges++;
            dividend = N'($urandom);
            if (done !== 1'b1) check_value("busy_in_shift", 32'(busy), 32'd1);
        end
        check_value("latency", 32'(edges), 32'(N + 1));
        check_value("quotient", 32'(quotient), 32'(exp_q));
        check_value("remainder", 32'(remainder), 32'(exp_r));
        check_value("busy_in_done", 32'(busy), 32'd1);
        if (b != '0) begin
            check_value("invariant", 32'(int'(quotient) * int'(b) + int'(remainder)), 32'(a));
            check_value("rem_lt_div", 32'(remainder < b), 32'd1);
        end
`ifdef RESTORING_DIVIDER_DIV0_FLAG_EN
        check_value("dbz_in_done", 32'(div_by_zero), 32'(b == '0));
`endif
        @(negedge clock);
        check_value("done_one_cycle", 32'(done), 32'd0);
        check_value("busy_idle", 32'(busy), 32'd0);
        check_value("quotient_hold", 32'(quotient), 32'(exp_q));
`ifdef RESTORING_DIVIDER_DIV0_FLAG_EN
        check_value("dbz_after_done", 32'(div_by_zero), 32'd0);
`endif
    endtask

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clock);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clock);
    endtask

    task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b);
        launch(a, b);
        finish_div(a, b, 1'b0);
    endtask

    initial begin
        logic [N:0]   step_a [4];
        logic [N-1:0] step_q [4];
        logic [N-1:0] ra, rb;
        int           stray;
        step_a[0] = 5'd1; step_a[1] = 5'd2; step_a[2] = 5'd2; step_a[3] = 5'd2;
        step_q[0] = 4'b0110; step_q[1] = 4'b1100; step_q[2] = 4'b1001; step_q[3] = 4'b0011;

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clock);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_quot", 32'(quotient), 32'd0);
        check_value("rst_rem", 32'(remainder), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 11/3 with per-step partial remainder and quotient register trace.
        launch(4'd11, 4'd3);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_value($sformatf("step_a%0d", i), 32'(dut.u_datapath.a_q), 32'(step_a[i]));
            check_value($sformatf("step_q%0d", i), 32'(dut.u_datapath.q_q), 32'(step_q[i]));
        end
        check_value("div11_3_done", 32'(done), 32'd1);
        check_value("div11_3_q", 32'(quotient), 32'd3);
        check_value("div11_3_r", 32'(remainder), 32'd2);
        @(negedge clock);
        check_value("div11_3_idle", 32'(busy), 32'd0);

        do_div(4'd6, 4'd11);
        do_div(4'd15, 4'd1);
        do_div(4'd9, 4'd0);
        do_div(4'd15, 4'd15);
        do_div(4'd0, 4'd7);

        // start held high across the whole operation: one done, then a re-launch.
        launch(4'd13, 4'd4);
        finish_div(4'd13, 4'd4, 1'b1);
        dividend = 4'd12;
        divisor  = 4'd5;
        @(negedge clock);
        check_value("relaunch_busy", 32'(busy), 32'd1);
        finish_div(4'd12, 4'd5, 1'b0);

        // Reset two cycles into an operation aborts it silently.
        launch(4'd7, 4'd2);
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_value("abort_busy", 32'(busy), 32'd0);
        check_value("abort_done", 32'(done), 32'd0);
        check_value("abort_quot", 32'(quotient), 32'd0);
        check_value("abort_rem", 32'(remainder), 32'd0);
        reset = 1'b0;
        stray = 0;
        repeat (N + 3) begin
            @(negedge clock);
            if (done === 1'b1) stray++;
        end
        check_value("abort_no_done", 32'(stray), 32'd0);
        do_div(4'd12, 4'd5);

        for (int i = 0; i < 30; i++) begin
            ra = N'($urandom);
            rb = (i % 7 == 0) ? '0 : N'($urandom);
            do_div(ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
